// File: rtl/bch_root_collector_p16.sv
// Collects zero flags from the 16-parallel Chien search, emits per-beat error masks,
// and compares the codeword root count against the error-locator degree.
module bch_root_collector_p16 #(
  parameter int M         = 13,
  parameter int P         = 16,
  parameter int NUM_BEATS = 512,
  parameter int IDX_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       lambda_deg,
  input  logic             sigma_valid,
  input  logic [P*M-1:0]   sigma_flat,
  output logic             err_valid,
  output logic [P-1:0]     err_mask,
  output logic [IDX_W-1:0] err_index,
  output logic [4:0]       root_cnt,
  output logic             busy,
  output logic             done,
  output logic             decode_fail
);

  typedef enum logic [1:0] {IDLE, COLLECT, FINAL} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0] err_index_q, err_index_d;
  logic [3:0]       deg_q, deg_d;
  logic [4:0]       root_cnt_q, root_cnt_d;
  logic             err_valid_q, err_valid_d;
  logic [P-1:0]     err_mask_q, err_mask_d;
  logic             done_q, done_d;
  logic             decode_fail_q, decode_fail_d;

  logic [P-1:0]     zero_hit;
  logic [4:0]       hit_cnt;
  logic [5:0]       cnt_sum;

  // Plain M-bit zero detect per lane; a zero evaluation marks a root of sigma.
  always_comb begin
    zero_hit = '0;
    hit_cnt  = '0;
    for (int i = 0; i < P; i++) begin
      zero_hit[i] = (sigma_flat[i*M +: M] == '0);
      hit_cnt     = hit_cnt + 5'(zero_hit[i]);
    end
    cnt_sum = {1'b0, root_cnt_q} + {1'b0, hit_cnt};
  end

  // NOTE: every _d signal gets its hold/default value first so no path through
  // the case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    err_index_d   = err_index_q;
    deg_d         = deg_q;
    root_cnt_d    = root_cnt_q;
    err_valid_d   = 1'b0;
    err_mask_d    = '0;
    done_d        = 1'b0;
    decode_fail_d = decode_fail_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          deg_d         = lambda_deg;
          root_cnt_d    = '0;
          beat_d        = '0;
          decode_fail_d = 1'b0;
          state_d       = COLLECT;
        end
      end
      COLLECT: begin
        if (sigma_valid) begin
          err_valid_d = 1'b1;
          err_mask_d  = zero_hit;
          err_index_d = beat_q;
          root_cnt_d  = (cnt_sum > 6'd31) ? 5'd31 : cnt_sum[4:0];
          if (beat_q == IDX_W'(NUM_BEATS - 1)) begin
            beat_d  = '0;
            state_d = FINAL;
          end else begin
            beat_d = beat_q + IDX_W'(1);
          end
        end
      end
      FINAL: begin
        // root_cnt_q already includes the last beat accepted on the previous edge.
        done_d        = 1'b1;
        decode_fail_d = (root_cnt_q != {1'b0, deg_q});
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      err_index_q   <= '0;
      deg_q         <= '0;
      root_cnt_q    <= '0;
      err_valid_q   <= 1'b0;
      err_mask_q    <= '0;
      done_q        <= 1'b0;
      decode_fail_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      err_index_q   <= err_index_d;
      deg_q         <= deg_d;
      root_cnt_q    <= root_cnt_d;
      err_valid_q   <= err_valid_d;
      err_mask_q    <= err_mask_d;
      done_q        <= done_d;
      decode_fail_q <= decode_fail_d;
    end
  end

  assign err_valid   = err_valid_q;
  assign err_mask    = err_mask_q;
  assign err_index   = err_index_q;
  assign root_cnt    = root_cnt_q;
  assign busy        = (state_q == COLLECT) || (state_q == FINAL);
  assign done        = done_q;
  assign decode_fail = decode_fail_q;

endmodule

// File: tb/tb_bch_root_collector_p16.sv
// Directed bench for bch_root_collector_p16: reset, clean, correctable,
// bubbled, saturating and back-to-back codewords.
module tb_bch_root_collector_p16;

  localparam int M     = 13;
  localparam int P     = 16;
  localparam int NB    = 512;
  localparam int IDX_W = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       lambda_deg;
  logic             sigma_valid;
  logic [P*M-1:0]   sigma_flat;
  logic             err_valid;
  logic [P-1:0]     err_mask;
  logic [IDX_W-1:0] err_index;
  logic [4:0]       root_cnt;
  logic             busy;
  logic             done;
  logic             decode_fail;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bch_root_collector_p16 dut (
    .clk(clk), .reset(reset), .start(start), .lambda_deg(lambda_deg),
    .sigma_valid(sigma_valid), .sigma_flat(sigma_flat),
    .err_valid(err_valid), .err_mask(err_mask), .err_index(err_index),
    .root_cnt(root_cnt), .busy(busy), .done(done), .decode_fail(decode_fail)
  );

  always #5 clk = ~clk;

  // Zero where requested; otherwise alternate low-bit and high-bit nonzero values.
  function automatic logic [P*M-1:0] make_sigma(input logic [P-1:0] zeros);
    logic [P*M-1:0] s;
    s = '0;
    for (int i = 0; i < P; i++)
      s[i*M +: M] = zeros[i] ? 13'h0000 : ((i % 2 == 1) ? 13'h1000 : 13'h0001);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] d);
    start      = 1'b1;
    lambda_deg = d;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [P-1:0] zeros);
    sigma_valid = 1'b1;
    sigma_flat  = make_sigma(zeros);
    tick();
    sigma_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sigma_valid = 1'b0; lambda_deg = '0; sigma_flat = '0;
    tick(); tick();
    reset = 1'b0;
    total_cnt++;
    if ({err_valid, err_mask, err_index, root_cnt, busy, done, decode_fail} !== 34'd0)
      $display("FAIL reset_state: got ev=%b mask=%h idx=%0d cnt=%0d busy=%b done=%b fail=%b, want all 0",
               err_valid, err_mask, err_index, root_cnt, busy, done, decode_fail);
    else pass_cnt++;

    do_start(4'd2);
    for (int j = 0; j < 100; j++) beat((j == 5) ? 16'hFFFF : 16'h0000);
    total_cnt++;
    if ({busy, root_cnt, err_index} !== {1'b1, 5'd16, 9'd99})
      $display("FAIL mid_word_state: got busy=%b cnt=%0d idx=%0d, want busy=1 cnt=16 idx=99",
               busy, root_cnt, err_index);
    else pass_cnt++;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if ({err_valid, err_mask, err_index, root_cnt, busy, done, decode_fail} !== 34'd0)
      $display("FAIL mid_word_reset: got ev=%b mask=%h idx=%0d cnt=%0d busy=%b done=%b fail=%b, want all 0",
               err_valid, err_mask, err_index, root_cnt, busy, done, decode_fail);
    else pass_cnt++;

    for (int k = 0; k < 3; k++) begin
      sigma_valid = 1'b1;
      sigma_flat  = '0;
      tick();
      total_cnt++;
      if ({err_valid, busy, done, err_mask} !== 19'd0)
        $display("FAIL idle_ignores_sigma: got ev=%b busy=%b done=%b mask=%h, want all 0",
                 err_valid, busy, done, err_mask);
      else pass_cnt++;
    end
    sigma_valid = 1'b0;
  endtask

  task automatic test_clean_word();
    do_start(4'd0);
    total_cnt++;
    if ({busy, root_cnt} !== {1'b1, 5'd0})
      $display("FAIL clean_start: got busy=%b cnt=%0d, want busy=1 cnt=0", busy, root_cnt);
    else pass_cnt++;
    for (int j = 0; j < NB; j++) begin
      sigma_valid = 1'b1;
      sigma_flat  = {P{13'h0001}};
      tick();
      total_cnt++;
      if ({err_valid, err_mask, err_index} !== {1'b1, 16'h0000, j[8:0]})
        $display("FAIL clean_beat: got ev=%b mask=%h idx=%0d, want ev=1 mask=0000 idx=%0d",
                 err_valid, err_mask, err_index, j);
      else pass_cnt++;
    end
    sigma_valid = 1'b0;
    total_cnt++;
    if ({done, busy} !== 2'b01)
      $display("FAIL clean_final_state: got done=%b busy=%b, want done=0 busy=1", done, busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done, decode_fail, root_cnt, err_valid, busy} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0})
      $display("FAIL clean_done: got done=%b fail=%b cnt=%0d ev=%b busy=%b, want 1 0 0 0 0",
               done, decode_fail, root_cnt, err_valid, busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0)
      $display("FAIL clean_done_pulse: got done=%b, want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_correctable();
    logic [P-1:0] z;
    do_start(4'd3);
    for (int j = 0; j < NB; j++) begin
      z = (j == 0) ? 16'h0001 : (j == 7) ? 16'h8000 : (j == 511) ? 16'h0010 : 16'h0000;
      beat(z);
      total_cnt++;
      if ({err_valid, err_mask, err_index} !== {1'b1, z, j[8:0]})
        $display("FAIL corr_beat: got ev=%b mask=%h idx=%0d, want ev=1 mask=%h idx=%0d",
                 err_valid, err_mask, err_index, z, j);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({done, decode_fail, root_cnt} !== {1'b1, 1'b0, 5'd3})
      $display("FAIL corr_done: got done=%b fail=%b cnt=%0d, want 1 0 3", done, decode_fail, root_cnt);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done, decode_fail, root_cnt} !== {1'b0, 1'b0, 5'd3})
      $display("FAIL corr_hold: got done=%b fail=%b cnt=%0d, want 0 0 3", done, decode_fail, root_cnt);
    else pass_cnt++;
  endtask

  task automatic test_bubbles();
    logic [P-1:0] z;
    int exp_cnt;
    exp_cnt = 0;
    do_start(4'd4);
    for (int j = 0; j < NB; j++) begin
      z = (j == 100) ? 16'h0008 : (j == 300) ? 16'h0200 : 16'h0000;
      beat(z);
      exp_cnt += $countones(z);
      total_cnt++;
      if ({err_valid, err_mask, err_index, root_cnt} !== {1'b1, z, j[8:0], 5'(exp_cnt)})
        $display("FAIL bubble_beat: got ev=%b mask=%h idx=%0d cnt=%0d, want ev=1 mask=%h idx=%0d cnt=%0d",
                 err_valid, err_mask, err_index, root_cnt, z, j, exp_cnt);
      else pass_cnt++;
      if (j < NB - 1) begin
        sigma_valid = 1'b0;
        sigma_flat  = '0;
        tick();
        total_cnt++;
        if ({err_valid, err_mask, err_index, done, root_cnt} !== {1'b0, 16'h0000, j[8:0], 1'b0, 5'(exp_cnt)})
          $display("FAIL bubble_hold: got ev=%b mask=%h idx=%0d done=%b cnt=%0d, want 0 0000 %0d 0 %0d",
                   err_valid, err_mask, err_index, done, root_cnt, j, exp_cnt);
        else pass_cnt++;
      end
    end
    tick();
    total_cnt++;
    if ({done, decode_fail, root_cnt} !== {1'b1, 1'b1, 5'd2})
      $display("FAIL bubble_done: got done=%b fail=%b cnt=%0d, want 1 1 2", done, decode_fail, root_cnt);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_start(4'd8);
    beat(16'hFFFF);
    total_cnt++;
    if (root_cnt !== 5'd16)
      $display("FAIL sat_beat0: got cnt=%0d, want 16", root_cnt);
    else pass_cnt++;
    beat(16'hFFFF);
    total_cnt++;
    if (root_cnt !== 5'd31)
      $display("FAIL sat_beat1: got cnt=%0d, want 31", root_cnt);
    else pass_cnt++;
    for (int j = 2; j < NB; j++) begin
      beat((j == 200) ? 16'h0001 : 16'h0000);
      if (j == 200) begin
        total_cnt++;
        if (root_cnt !== 5'd31)
          $display("FAIL sat_hold: got cnt=%0d, want 31", root_cnt);
        else pass_cnt++;
      end
    end
    tick();
    total_cnt++;
    if ({done, decode_fail, root_cnt} !== {1'b1, 1'b1, 5'd31})
      $display("FAIL sat_done: got done=%b fail=%b cnt=%0d, want 1 1 31", done, decode_fail, root_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_start(4'd1);
    for (int j = 0; j < NB; j++) beat((j == 50) ? 16'h0004 : 16'h0000);
    // State is FINAL now: this start must be ignored.
    start      = 1'b1;
    lambda_deg = 4'd5;
    tick();
    start = 1'b0;
    total_cnt++;
    if ({done, decode_fail, busy, root_cnt} !== {1'b1, 1'b0, 1'b0, 5'd1})
      $display("FAIL b2b_done: got done=%b fail=%b busy=%b cnt=%0d, want 1 0 0 1",
               done, decode_fail, busy, root_cnt);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b00)
      $display("FAIL b2b_final_start_ignored: got busy=%b done=%b, want 0 0", busy, done);
    else pass_cnt++;
    do_start(4'd5);
    total_cnt++;
    if ({busy, root_cnt, err_valid} !== {1'b1, 5'd0, 1'b0})
      $display("FAIL b2b_restart: got busy=%b cnt=%0d ev=%b, want 1 0 0", busy, root_cnt, err_valid);
    else pass_cnt++;
    for (int j = 0; j < NB; j++) beat((j == 0) ? 16'h001F : 16'h0000);
    tick();
    total_cnt++;
    if ({done, decode_fail, root_cnt} !== {1'b1, 1'b0, 5'd5})
      $display("FAIL b2b_second_done: got done=%b fail=%b cnt=%0d, want 1 0 5", done, decode_fail, root_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean_word();
    test_correctable();
    test_bubbles();
    test_saturation();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bch_root_collector_p16.md
Name: bch_root_collector_p16

Overview:
- Sits directly downstream of the 16-parallel Chien search in the t=8 BCH decoder over GF(2^13).
- Each accepted cycle it takes the 16 registered sigma evaluations, flags every zero as an error location and emits a 16-bit error mask, tagged with a beat index, to the correction stage.
- It also counts the roots across the whole codeword and compares that count with the error-locator degree to flag uncorrectable words.

Parameters:
M, 13, symbol width in bits (GF(2^13)).
P, 16, evaluations per cycle (parallelism).
NUM_BEATS, 512, accepted sigma beats per codeword (P*NUM_BEATS >= n).
IDX_W, 9, width of beat index (ceil(log2(NUM_BEATS))).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous reset, active-high.
start  input  1  one-cycle pulse that begins a codeword; sampled only in IDLE.
lambda_deg  input  4  degree of the error-locator polynomial (0..8), sampled with start.
sigma_valid  input  1  sigma_flat holds a valid Chien beat this cycle.
sigma_flat  input  P*M  sigma k (k=1..16) occupies bits [k*M-1:(k-1)*M].
err_valid  output  1  err_mask/err_index valid.
err_mask  output  P  bit i = 1 when sigma(i+1) == 0.
err_index  output  IDX_W  beat number of err_mask, 0..NUM_BEATS-1.
root_cnt  output  5  running root count, saturating at 31.
busy  output  1  high in COLLECT and FINAL.
done  output  1  one-cycle pulse at end of codeword.
decode_fail  output  1  valid with done: root_cnt != latched lambda_deg.

Behaviour:
- Reset: the synchronous, active-high reset wins over every other input on the same edge. After the reset edge every output is 0, state is IDLE, beat counter = 0 and latched degree = 0. A reset mid-codeword abandons the word, with no done pulse.
- FSM states: IDLE, COLLECT, FINAL.
- IDLE:
  - start=1 latches lambda_deg, clears root_cnt and the beat counter, and moves to COLLECT.
  - sigma_valid is ignored in IDLE.
- COLLECT:
  - Each edge with sigma_valid=1 accepts one beat and registers err_mask[i] = (sigma(i+1) == 0). The mask is a pure M-bit zero compare; no GF arithmetic.
  - The same edge sets err_valid=1 and err_index = beat counter.
  - The same edge sets root_cnt = min(31, root_cnt + popcount(mask)).
  - Latency is 1 cycle from accepted beat to err_valid.
  - With sigma_valid=0: err_valid=0, err_mask is forced to 0, and err_index, root_cnt and the counter hold.
  - start is ignored outside IDLE.
- Last beat (counter == NUM_BEATS-1): accepting it moves the state to FINAL and wraps the counter to 0.
- FINAL: lasts exactly one cycle.
  - On the FINAL edge, done <= 1 and decode_fail <= (root_cnt != latched lambda_deg). Here root_cnt already includes the last beat.
  - Next state is IDLE.
  - sigma_valid in FINAL is ignored.
  - err_valid is 0 in FINAL.
- Timing summary: if the last beat is accepted at edge E, err_valid is high after E, and done/decode_fail are high after E+1 for exactly one cycle. busy is low again after E+1.
- decode_fail and root_cnt hold their values until the next start.
- Degree 0 with no roots gives decode_fail=0. Degree 0 with any root gives decode_fail=1.
- Saturation: root_cnt never wraps. Any word with more than 31 roots reports 31 and fail=1.
- A start in the same cycle as done (state FINAL) is ignored. A new word may start on the cycle after done.
- The error location for err_mask[i] at err_index j is Chien evaluation point number 16*j + i + 1. Mapping that point to a codeword bit is done downstream.

Test Plan:
- Reset mid-word: start with deg=2, accept 100 beats, assert reset for 1 cycle -> all outputs 0 and state IDLE. Then sigma_valid with all-zero sigmas while idle -> err_valid stays 0.
- Clean word: start with deg=0, feed 512 beats of sigma all = 13'h0001 -> 512 err_valid pulses, all masks 0, err_index 0..511. Then done=1, root_cnt=0, decode_fail=0 one cycle after the last err_valid.
- Correctable word: start with deg=3; zeros at beat 0 bit 0, beat 7 bit 15, beat 511 bit 4.
  - Expected: err_mask 16'h0001 @idx 0, 16'h8000 @idx 7, 16'h0010 @idx 511.
  - Expected: root_cnt=3, decode_fail=0.
- Failure and bubbles: start with deg=4; only 2 zeros across the word; sigma_valid toggling 1-0-1 throughout -> index advances only on valid beats; done after exactly 512 accepted beats; decode_fail=1.
- Saturation: start with deg=8; beats 0 and 1 all-zero sigma (32 roots) -> root_cnt 16 then 31, held at 31 to the end; decode_fail=1.
- Back-to-back words: a start pulse during FINAL is ignored. A start on the cycle after done begins a new word with root_cnt cleared to 0.
